// File: rtl/a2d_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : a2d_seq_pkg
// Function : Shared types and constants for the A2D conversion sequencer:
//            FSM state encoding, SPI command framing and channel count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package a2d_seq_pkg;

  // Sequencer states: idle, first SPI transaction, one-cycle spacer, second
  // SPI transaction (the one whose received word carries the result).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX1  = 2'd1,
    GAP  = 2'd2,
    TX2  = 2'd3
  } state_t;

  localparam logic [1:0]  C_CMD_PREFIX = 2'b00;
  localparam logic [10:0] C_CMD_PAD    = 11'h000;
  localparam int          C_NUM_CHNL   = 8;
  localparam int          C_CHNL_W     = 3;
  localparam int          C_RES_W      = 12;

  // Build the 16-bit ADC command word for a given channel.
  function automatic logic [15:0] make_cmd(input logic [C_CHNL_W-1:0] ch);
    return {C_CMD_PREFIX, ch, C_CMD_PAD};
  endfunction

endpackage

`default_nettype wire

// File: rtl/a2d_res_table.sv
//------------------------------------------------------------------------------
// Module   : a2d_res_table
// Function : Eight-entry scan result table; one synchronous write port and
//            one combinational read port. Cleared by asynchronous reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module a2d_res_table
  import a2d_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [C_CHNL_W-1:0] wr_addr,
  input  logic [C_RES_W-1:0]  wr_data,
  input  logic [C_CHNL_W-1:0] rd_addr,
  output logic [C_RES_W-1:0]  rd_data
);

  logic [C_RES_W-1:0] r_mem [C_NUM_CHNL];

  // Table storage: cleared on reset, one entry written per completed scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_NUM_CHNL; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/a2d_seq.sv
//------------------------------------------------------------------------------
// Module   : a2d_seq
// Function : A2D conversion sequencer. Each conversion issues two identical
//            SPI commands to an external ADC; the word received on the second
//            transaction is the result. Supports single conversions on a
//            chosen channel and a round-robin scan of all channels into a
//            result table.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module a2d_seq
  import a2d_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                strt_cnv,
  input  logic [C_CHNL_W-1:0] chnnl,
  input  logic                scan_en,
  output logic                cnv_cmplt,
  output logic [C_RES_W-1:0]  res,
  input  logic [C_CHNL_W-1:0] rd_chnl,
  output logic [C_RES_W-1:0]  rd_res,
  output logic                wrt,
  output logic [15:0]         cmd,
  input  logic                done,
  input  logic [15:0]         rd_data
);

  state_t              r_state;
  logic                r_is_scan;
  logic [C_CHNL_W-1:0] r_scan_ptr;

  logic                w_xfer_done;
  logic                w_tbl_we;
  logic                w_unused_hi;

  // done is still high from the previous idle period during the cycle wrt is
  // asserted, so it only counts as completion once the request has dropped.
  assign w_xfer_done = done && !wrt;
  assign w_tbl_we    = (r_state == TX2) && w_xfer_done && r_is_scan;
  assign w_unused_hi = ^rd_data[15:C_RES_W];

  // Conversion sequencer: issues both SPI requests and captures the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      wrt        <= 1'b0;
      cmd        <= 16'h0000;
      cnv_cmplt  <= 1'b0;
      res        <= '0;
      r_is_scan  <= 1'b0;
      r_scan_ptr <= '0;
    end else begin
      wrt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (strt_cnv) begin
            wrt       <= 1'b1;
            cmd       <= make_cmd(chnnl);
            r_is_scan <= 1'b0;
            cnv_cmplt <= 1'b0;
            r_state   <= TX1;
          end else if (scan_en) begin
            wrt       <= 1'b1;
            cmd       <= make_cmd(r_scan_ptr);
            r_is_scan <= 1'b1;
            cnv_cmplt <= 1'b0;
            r_state   <= TX1;
          end
        end
        TX1: begin
          if (w_xfer_done) begin
            r_state <= GAP;
          end
        end
        GAP: begin
          wrt     <= 1'b1;
          r_state <= TX2;
        end
        TX2: begin
          if (w_xfer_done) begin
            res       <= rd_data[C_RES_W-1:0];
            cnv_cmplt <= 1'b1;
            r_state   <= IDLE;
            if (r_is_scan) begin
              r_scan_ptr <= r_scan_ptr + 3'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  a2d_res_table u_res_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (w_tbl_we),
    .wr_addr (r_scan_ptr),
    .wr_data (rd_data[C_RES_W-1:0]),
    .rd_addr (rd_chnl),
    .rd_data (rd_res)
  );

endmodule

`default_nettype wire

// File: tb/tb_a2d_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_a2d_seq
// Function : Self-checking bench for a2d_seq with a behavioural SPI slave and
//            a result-table reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_a2d_seq;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        strt_cnv = 1'b0;
  logic [2:0]  chnnl    = 3'd0;
  logic        scan_en  = 1'b0;
  logic [2:0]  rd_chnl  = 3'd0;
  logic        done     = 1'b1;
  logic [15:0] rd_data  = 16'h0000;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic [11:0] rd_res;
  logic        wrt;
  logic [15:0] cmd;

  a2d_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .scan_en   (scan_en),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .rd_chnl   (rd_chnl),
    .rd_res    (rd_res),
    .wrt       (wrt),
    .cmd       (cmd),
    .done      (done),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // SPI slave model: every request is logged with its response and latency.
  logic [15:0] cmd_q[$];
  logic [15:0] resp_q[$];
  int          wcyc_q[$];
  int          lat_q[$];
  int          resp_mode  = 0;   // 0: 0x0100+ch, 1: fixed, 2: random, 3: 0x0200+ch
  logic [15:0] fixed_resp = 16'h0000;

  initial begin : spi_model
    logic [15:0] c;
    logic [15:0] r;
    int          lat;
    forever begin
      @(negedge clk);
      if (wrt === 1'b1 && rst_n === 1'b1) begin
        c = cmd;
        case (resp_mode)
          0:       r = 16'h0100 + {13'd0, c[13:11]};
          1:       r = fixed_resp;
          2:       r = 16'($urandom);
          default: r = 16'h0200 + {13'd0, c[13:11]};
        endcase
        lat = $urandom_range(1, 5);
        cmd_q.push_back(c);
        resp_q.push_back(r);
        wcyc_q.push_back(cyc);
        lat_q.push_back(lat);
        @(posedge clk);
        #1 done = 1'b0;
        repeat (lat) @(posedge clk);
        #1;
        rd_data = r;
        done    = 1'b1;
      end
    end
  end

  // wrt must never stay high for two consecutive cycles.
  initial begin : wrt_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (wrt === 1'b1) check_val("wrt_one_cycle", {31'd0, prev}, 32'd0);
      prev = wrt;
    end
  end

  // Reference model of the architecturally visible state.
  logic [11:0] exp_tab [8];
  int          exp_ptr = 0;
  logic [11:0] exp_res = 12'h000;

  task automatic clear_model();
    for (int i = 0; i < 8; i++) exp_tab[i] = 12'h000;
    exp_ptr = 0;
    exp_res = 12'h000;
  endtask

  task automatic clear_log();
    cmd_q.delete();
    resp_q.delete();
    wcyc_q.delete();
    lat_q.delete();
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_chnl = 3'(i);
      #1;
      check_val($sformatf("%s_tab%0d", tag, i), {20'd0, rd_res}, {20'd0, exp_tab[i]});
    end
  endtask

  // Wait for the current conversion to start (cnv_cmplt low) and finish.
  task automatic wait_conv();
    int k;
    k = 0;
    while (cnv_cmplt !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    k = 0;
    while (cnv_cmplt !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    if (cnv_cmplt !== 1'b1) check_val("conv_timeout", {31'd0, cnv_cmplt}, 32'd1);
  endtask

  // Check one finished conversion against the model, then update the model.
  task automatic check_conv(input string tag, input logic [2:0] ch, input bit is_scan);
    logic [15:0] exp_cmd;
    exp_cmd = {2'b00, ch, 11'h000};
    check_val({tag, "_nwrt"}, cmd_q.size(), 32'd2);
    if (cmd_q.size() == 2) begin
      check_val({tag, "_cmd1"}, {16'd0, cmd_q[0]}, {16'd0, exp_cmd});
      check_val({tag, "_cmd2"}, {16'd0, cmd_q[1]}, {16'd0, exp_cmd});
      check_val({tag, "_spacing"}, {31'd0, (wcyc_q[1] - wcyc_q[0]) >= lat_q[0] + 3}, 32'd1);
      exp_res = resp_q[1][11:0];
      if (is_scan) begin
        exp_tab[ch] = resp_q[1][11:0];
        exp_ptr     = (exp_ptr + 1) % 8;
      end
    end
    check_val({tag, "_res"},   {20'd0, res}, {20'd0, exp_res});
    check_val({tag, "_cmplt"}, {31'd0, cnv_cmplt}, 32'd1);
    check_val({tag, "_cmdhold"}, {16'd0, cmd}, {16'd0, exp_cmd});
    clear_log();
  endtask

  task automatic single(input logic [2:0] ch);
    @(negedge clk);
    strt_cnv = 1'b1;
    chnnl    = ch;
    @(negedge clk);
    strt_cnv = 1'b0;
    wait_conv();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_cmplt"}, {31'd0, cnv_cmplt}, 32'd0);
    check_val({tag, "_res"},   {20'd0, res}, 32'd0);
    check_val({tag, "_wrt"},   {31'd0, wrt}, 32'd0);
    check_val({tag, "_cmd"},   {16'd0, cmd}, 32'd0);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    logic [2:0] ch;
    clear_model();

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check_table("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single conversion on channel 5
    resp_mode  = 1;
    fixed_resp = 16'hF123;
    single(3'd5);
    check_conv("single5", 3'd5, 1'b0);
    check_val("single5_val", {20'd0, res}, 32'h123);
    check_table("single5");

    // Full scan of all channels plus a ninth conversion that wraps to 0
    resp_mode = 0;
    @(negedge clk);
    scan_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      wait_conv();
      check_conv("scan", 3'(exp_ptr), 1'b1);
    end
    resp_mode = 3;
    check_table("scan8");
    @(negedge clk);
    scan_en = 1'b0;
    wait_conv();
    check_conv("scan9", 3'(exp_ptr), 1'b1);
    check_table("scan9");
    repeat (12) @(negedge clk);
    check_val("scan_stopped", cmd_q.size(), 32'd0);

    // strt_cnv beats scan_en; the following scan uses the unchanged pointer
    resp_mode = 2;
    @(negedge clk);
    scan_en  = 1'b1;
    strt_cnv = 1'b1;
    chnnl    = 3'd3;
    @(negedge clk);
    strt_cnv = 1'b0;
    wait_conv();
    check_conv("prio", 3'd3, 1'b0);
    @(negedge clk);
    scan_en = 1'b0;
    wait_conv();
    check_conv("prio_scan", 3'(exp_ptr), 1'b1);
    check_table("prio");

    // strt_cnv during TX1 is ignored and not queued
    @(negedge clk);
    strt_cnv = 1'b1;
    chnnl    = 3'd2;
    @(negedge clk);
    strt_cnv = 1'b0;
    @(negedge clk);
    strt_cnv = 1'b1;
    chnnl    = 3'd7;
    @(negedge clk);
    strt_cnv = 1'b0;
    wait_conv();
    check_conv("hs", 3'd2, 1'b0);
    repeat (12) @(negedge clk);
    check_val("hs_no_queue", cmd_q.size(), 32'd0);

    // Randomized single conversions
    for (int n = 0; n < 6; n++) begin
      ch = 3'($urandom_range(0, 7));
      single(ch);
      check_conv($sformatf("rnd%0d", n), ch, 1'b0);
    end
    check_table("rnd");

    // Reset while in TX2 aborts the conversion
    single_start : begin
      @(negedge clk);
      strt_cnv = 1'b1;
      chnnl    = 3'd4;
      @(negedge clk);
      strt_cnv = 1'b0;
    end
    k = 0;
    while (cmd_q.size() < 2 && k < 200) begin @(negedge clk); k++; end
    check_val("tx2_reached", cmd_q.size(), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    clear_model();
    @(negedge clk);
    check_reset_outputs("midrst_next");
    check_table("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    clear_log();
    single(3'd1);
    check_conv("post_rst", 3'd1, 1'b0);

    // Scan stopped during the channel-6 conversion
    resp_mode = 0;
    @(negedge clk);
    scan_en = 1'b1;
    for (int n = 0; n < 6; n++) begin
      wait_conv();
      check_conv("scan_b", 3'(exp_ptr), 1'b1);
    end
    @(negedge clk);
    scan_en = 1'b0;
    wait_conv();
    check_conv("scan_ch6", 3'd6, 1'b1);
    repeat (15) @(negedge clk);
    check_val("ch6_idle_nwrt", cmd_q.size(), 32'd0);
    check_val("ch6_idle_cmplt", {31'd0, cnv_cmplt}, 32'd1);
    check_table("ch6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
